// File: rtl/xor16_checksum.sv
// xor16_checksum: streaming 16-bit XOR checksum over valid/ready packets.
// Define XOR16_CKSUM_COUNT_EN to add the saturating out_count/out_ovf word counter.
module xor16_gate (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  assign y = a ^ b;
endmodule

module xor16_checksum #(
  parameter logic [15:0] SEED = 16'h0000
`ifdef XOR16_CKSUM_COUNT_EN
  , parameter int COUNT_W = 8
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
`ifdef XOR16_CKSUM_COUNT_EN
  , output logic [COUNT_W-1:0] out_count,
  output logic                 out_ovf
`endif
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_nxt;
  logic [15:0] acc, fold;
  logic take, give;
  // acc holds SEED whenever the engine is idle, so the fold needs no seed mux
  xor16_gate u_fold (.a(acc), .b(in_data), .y(fold));
  assign take = in_valid && in_ready;
  assign give = out_valid && out_ready;
  always_comb begin
    state_nxt = state == HOLD ? (give ? IDLE : HOLD) : take ? (in_last ? HOLD : ACCUM) : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= SEED;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= state_nxt != HOLD;
      if (take && !in_last) acc <= fold;
      if (take && in_last) begin
        out_data  <= fold;
        out_valid <= 1'b1;
      end
      if (give) begin
        out_valid <= 1'b0;
        acc       <= SEED;
      end
    end
  end
`ifdef XOR16_CKSUM_COUNT_EN
  localparam logic [COUNT_W-1:0] CMAX = '1;
  logic [COUNT_W-1:0] cnt, cnt_nxt;
  logic ovf, ovf_nxt;
  // ovf flags a word arriving while the count is already pinned at CMAX
  assign cnt_nxt = state == IDLE ? COUNT_W'(1) : cnt == CMAX ? cnt : cnt + COUNT_W'(1);
  assign ovf_nxt = state != IDLE && (ovf || cnt == CMAX);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      ovf       <= 1'b0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (take) begin
        cnt <= cnt_nxt;
        ovf <= ovf_nxt;
      end
      if (take && in_last) begin
        out_count <= cnt_nxt;
        out_ovf   <= ovf_nxt;
      end
      if (give) begin
        out_count <= '0;
        out_ovf   <= 1'b0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_xor16_checksum.sv
// tb_xor16_checksum: directed scoreboard bench for xor16_checksum.
module tb_xor16_checksum;
  localparam logic [15:0] SEED = 16'h0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic in_ready;
  logic [15:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] dq[$];
  int cq[$];
  logic [15:0] acc_m = SEED;
  int n_m = 0;
`ifdef XOR16_CKSUM_COUNT_EN
  localparam int CW = 2;
  localparam int CMAX_M = (1 << CW) - 1;
  logic [CW-1:0] out_count;
  logic out_ovf;
`endif

  always #5 clk = ~clk;

  xor16_checksum #(
    .SEED(SEED)
`ifdef XOR16_CKSUM_COUNT_EN
    , .COUNT_W(CW)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef XOR16_CKSUM_COUNT_EN
    , .out_count(out_count),
    .out_ovf(out_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("accept", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    acc_m = acc_m ^ d;
    n_m++;
    if (l) begin
      dq.push_back(acc_m);
      cq.push_back(n_m);
      acc_m = SEED;
      n_m = 0;
    end
  endtask

  task automatic take(input string tag);
    int t;
    logic [15:0] exp_d;
    int n;
    t = 0;
    out_ready = 1'b1;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
    exp_d = dq.size() > 0 ? dq.pop_front() : 16'hxxxx;
    n = cq.size() > 0 ? cq.pop_front() : -1;
    chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
`ifdef XOR16_CKSUM_COUNT_EN
    chk({tag, "_count"}, 32'(out_count), 32'(n > CMAX_M ? CMAX_M : n));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(n > CMAX_M));
`endif
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_clr"}, 32'(out_valid), 0);
    chk({tag, "_rdy_back"}, 32'(in_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(in_ready), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
`ifdef XOR16_CKSUM_COUNT_EN
    chk("rst_count", 32'(out_count), 0);
    chk("rst_ovf", 32'(out_ovf), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_pre_edge", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("rdy_post_edge", 32'(in_ready), 1);

    send(16'h1234, 1'b0);
    chk("tput_rdy1", 32'(in_ready), 1);
    send(16'h00FF, 1'b0);
    chk("tput_rdy2", 32'(in_ready), 1);
    send(16'hF0F0, 1'b1);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_rdy_low", 32'(in_ready), 0);
    chk("e23b_const", 32'(out_data), 32'h0000_E23B);
    take("p3");

    send(16'hA5A5, 1'b1);
    take("single");

    send(16'hBEEF, 1'b0);
    send(16'hBEEF, 1'b1);
    take("cancel");

    send(16'h1111, 1'b1);
    in_valid = 1'b1;
    in_data = 16'hFFFF;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_data", 32'(out_data), 32'h0000_1111);
      chk("bp_rdy", 32'(in_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    take("bp");
    send(16'h0002, 1'b1);
    take("after_bp");

    send(16'h1000, 1'b0);
    send(16'h2000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    acc_m = SEED;
    n_m = 0;
    #1;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_rdy", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'h0001, 1'b1);
    chk("abort_const", 32'(out_data), 1);
    take("abort");

    for (int i = 1; i <= 5; i++) send(16'(i), i == 5);
    take("sat5");
    send(16'h00AA, 1'b0);
    send(16'h5500, 1'b1);
    take("two");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
